// File: rtl/senales_impresora.sv
// senales_impresora
// Control FSM for a printer/scanner/copier front panel. Runs print jobs and
// copy jobs (scan followed by print), tracks colour/black ink and drives two
// 7-segment status digits.
//
// Ports
//   clk             : system clock, rising edge
//   reset           : synchronous, active-high
//   prendido        : power switch, 0 = OFF
//   color           : job ink select, 1 = colour, 0 = black
//   escanear        : copy request (scan then print)
//   imprimir        : print request (wins over escanear)
//   ajustes_escaner : scan resolution 0..3, bit 0 = MSB
//   rellenar_color  : load colour ink with INK_MAX
//   rellenar_negro  : load black ink with INK_MAX
//   paginas         : pages-1 (0..3), bit 0 = MSB
//   esc_escaner     : scan head active (registered)
//   fin_color       : colour ink empty (decoded from the ink counter)
//   fin_negro       : black ink empty (decoded from the ink counter)
//   display1        : state digit, [0:6] = segments a..g, active-high
//   display2        : job digit, same encoding
module senales_impresora #(
  parameter int INK_MAX   = 7,
  parameter int PAGE_CYC  = 2,
  parameter int SCAN_BASE = 2
) (
  input  logic       prendido,
  input  logic       color,
  input  logic       escanear,
  input  logic       imprimir,
  input  logic [0:1] ajustes_escaner,
  input  logic       reset,
  input  logic       clk,
  input  logic       rellenar_color,
  input  logic       rellenar_negro,
  input  logic [0:1] paginas,
  output logic       esc_escaner,
  output logic       fin_color,
  output logic       fin_negro,
  output logic [0:6] display1,
  output logic [0:6] display2
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_PRINT  = 3'd3,
    ST_DONE   = 3'd4,
    ST_NO_INK = 3'd5
  } state_t;

  // Digit index 7 decodes to a blank display.
  localparam logic [2:0] DIG_BLANK = 3'd7;

  // Segment encoder: MSB of the result is segment a.
  function automatic logic [6:0] f_seg(input logic [2:0] dig);
    logic [6:0] seg;
    case (dig)
      3'd0:    seg = 7'b1111110;
      3'd1:    seg = 7'b0110000;
      3'd2:    seg = 7'b1101101;
      3'd3:    seg = 7'b1111001;
      3'd4:    seg = 7'b0110011;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  state_t     r_state;
  logic [2:0] r_ink_color;
  logic [2:0] r_ink_negro;
  logic       r_job_color;
  logic [2:0] r_pages;      // pages still to print, 1..4 during a job
  logic [1:0] r_ajustes;
  logic [3:0] r_scan_cnt;   // scan cycles remaining minus one
  logic [1:0] r_page_cnt;   // cycle index inside the current page

  state_t     w_state_nx;
  logic [2:0] w_pages_nx;
  logic [1:0] w_ajustes_nx;
  logic       w_job_color_nx;
  logic [3:0] w_scan_nx;
  logic [1:0] w_page_cnt_nx;
  logic       w_dec_color;
  logic       w_dec_negro;
  logic [2:0] w_ink_sel;
  logic [2:0] w_ink_color_nx;
  logic [2:0] w_ink_negro_nx;
  logic [2:0] w_dig1_nx;
  logic [2:0] w_dig2_nx;

  assign w_ink_sel = r_job_color ? r_ink_color : r_ink_negro;
  assign fin_color = (r_ink_color == 3'd0);
  assign fin_negro = (r_ink_negro == 3'd0);

  // Next-state and job bookkeeping for the panel FSM.
  always_comb begin
    w_state_nx     = r_state;
    w_pages_nx     = r_pages;
    w_ajustes_nx   = r_ajustes;
    w_job_color_nx = r_job_color;
    w_scan_nx      = r_scan_cnt;
    w_page_cnt_nx  = r_page_cnt;
    w_dec_color    = 1'b0;
    w_dec_negro    = 1'b0;
    if (!prendido) begin
      w_state_nx    = ST_OFF;
      w_pages_nx    = 3'd0;
      w_ajustes_nx  = 2'd0;
      w_scan_nx     = 4'd0;
      w_page_cnt_nx = 2'd0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nx = ST_IDLE;
        end
        ST_IDLE, ST_DONE: begin
          if (imprimir) begin
            w_job_color_nx = color;
            w_pages_nx     = {1'b0, paginas} + 3'd1;
            w_page_cnt_nx  = 2'd0;
            w_state_nx     = ST_PRINT;
          end else if (escanear) begin
            w_job_color_nx = color;
            w_pages_nx     = {1'b0, paginas} + 3'd1;
            w_ajustes_nx   = ajustes_escaner;
            // Load length-1 so the head stays active for the full count.
            w_scan_nx      = 4'(SCAN_BASE - 1) + {1'b0, ajustes_escaner, 1'b0};
            w_page_cnt_nx  = 2'd0;
            w_state_nx     = ST_SCAN;
          end else begin
            w_state_nx = r_state;
          end
        end
        ST_SCAN: begin
          if (r_scan_cnt == 4'd0) begin
            w_state_nx    = ST_PRINT;
            w_page_cnt_nx = 2'd0;
          end else begin
            w_scan_nx = r_scan_cnt - 4'd1;
          end
        end
        ST_PRINT: begin
          // Ink is checked only on the first cycle of a page.
          if ((r_page_cnt == 2'd0) && (w_ink_sel == 3'd0)) begin
            w_state_nx = ST_NO_INK;
          end else if (r_page_cnt == 2'(PAGE_CYC - 1)) begin
            w_dec_color   = r_job_color;
            w_dec_negro   = !r_job_color;
            w_page_cnt_nx = 2'd0;
            w_pages_nx    = r_pages - 3'd1;
            if (r_pages == 3'd1) begin
              w_state_nx = ST_DONE;
            end else begin
              w_state_nx = ST_PRINT;
            end
          end else begin
            w_page_cnt_nx = r_page_cnt + 2'd1;
          end
        end
        ST_NO_INK: begin
          if (r_job_color ? rellenar_color : rellenar_negro) begin
            w_state_nx = ST_PRINT;
          end else begin
            w_state_nx = ST_NO_INK;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // Ink counters: a refill overrides a decrement; reset never touches them.
  always_comb begin
    if (rellenar_color) begin
      w_ink_color_nx = 3'(INK_MAX);
    end else if (w_dec_color && !reset) begin
      w_ink_color_nx = r_ink_color - 3'd1;
    end else begin
      w_ink_color_nx = r_ink_color;
    end
    if (rellenar_negro) begin
      w_ink_negro_nx = 3'(INK_MAX);
    end else if (w_dec_negro && !reset) begin
      w_ink_negro_nx = r_ink_negro - 3'd1;
    end else begin
      w_ink_negro_nx = r_ink_negro;
    end
  end

  // Display digits decoded from the next state so the outputs can be registered.
  always_comb begin
    case (w_state_nx)
      ST_IDLE:   w_dig1_nx = 3'd0;
      ST_SCAN:   w_dig1_nx = 3'd1;
      ST_PRINT:  w_dig1_nx = 3'd2;
      ST_DONE:   w_dig1_nx = 3'd3;
      ST_NO_INK: w_dig1_nx = 3'd4;
      default:   w_dig1_nx = DIG_BLANK;
    endcase
    case (w_state_nx)
      ST_SCAN:             w_dig2_nx = {1'b0, w_ajustes_nx};
      ST_PRINT, ST_NO_INK: w_dig2_nx = w_pages_nx;
      default:             w_dig2_nx = DIG_BLANK;
    endcase
  end

  // State, job registers, ink counters and registered outputs.
  always_ff @(posedge clk) begin
    r_ink_color <= w_ink_color_nx;
    r_ink_negro <= w_ink_negro_nx;
    if (reset) begin
      r_state     <= prendido ? ST_IDLE : ST_OFF;
      r_pages     <= 3'd0;
      r_ajustes   <= 2'd0;
      r_job_color <= 1'b0;
      r_scan_cnt  <= 4'd0;
      r_page_cnt  <= 2'd0;
      esc_escaner <= 1'b0;
      display1    <= prendido ? f_seg(3'd0) : f_seg(DIG_BLANK);
      display2    <= f_seg(DIG_BLANK);
    end else begin
      r_state     <= w_state_nx;
      r_pages     <= w_pages_nx;
      r_ajustes   <= w_ajustes_nx;
      r_job_color <= w_job_color_nx;
      r_scan_cnt  <= w_scan_nx;
      r_page_cnt  <= w_page_cnt_nx;
      esc_escaner <= (w_state_nx == ST_SCAN);
      display1    <= f_seg(w_dig1_nx);
      display2    <= f_seg(w_dig2_nx);
    end
  end

endmodule

// File: tb/tb_senales_impresora.sv
`timescale 1ns/1ps
module tb_senales_impresora;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] SB = 7'b0000000;

  logic       clk = 1'b0;
  logic       reset, prendido, color, escanear, imprimir;
  logic       rellenar_color, rellenar_negro;
  logic [0:1] ajustes, paginas;
  logic       esc_escaner, fin_color, fin_negro;
  logic [0:6] display1, display2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  senales_impresora dut (
    .prendido(prendido), .color(color), .escanear(escanear), .imprimir(imprimir),
    .ajustes_escaner(ajustes), .reset(reset), .clk(clk),
    .rellenar_color(rellenar_color), .rellenar_negro(rellenar_negro),
    .paginas(paginas), .esc_escaner(esc_escaner), .fin_color(fin_color),
    .fin_negro(fin_negro), .display1(display1), .display2(display2)
  );

  typedef struct {
    logic       rst, on, col, esc, imp;
    logic [1:0] aj, pag;
    logic       rc, rn;
    logic [6:0] d1, d2;
    logic       e, fc, fn;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_end(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (display1 == S3 || display1 == S4) break;
      tick();
    end
  endtask

  task automatic do_print(input logic c, input logic [1:0] p, input logic efc, input logic efn,
                          input string nm);
    color = c; paginas = p; imprimir = 1'b1;
    tick();
    imprimir = 1'b0;
    wait_end(40);
    chk({nm, "_d1"}, display1, S3);
    chk({nm, "_fc"}, fin_color, efc);
    chk({nm, "_fn"}, fin_negro, efn);
  endtask

  task automatic copy_job(input logic [6:0] exp_end, input int exp_print, input string nm);
    int n;
    color = 1'b0; ajustes = 2'd3; paginas = 2'd3; escanear = 1'b1;
    tick();
    escanear = 1'b0;
    chk({nm, "_esc0"}, esc_escaner, 1);
    chk({nm, "_d1scan"}, display1, S1);
    chk({nm, "_d2scan"}, display2, S3);
    n = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (esc_escaner) n++;
      else break;
    end
    chk({nm, "_scan_len"}, n, 8);
    chk({nm, "_d1print"}, display1, S2);
    chk({nm, "_d2pages"}, display2, S4);
    n = 1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (display1 == S2) n++;
      else break;
    end
    chk({nm, "_print_len"}, n, exp_print);
    chk({nm, "_d1end"}, display1, exp_end);
  endtask

  initial begin
    // rst on col esc imp aj pag rc rn | d1 d2 esc fc fn
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, S0, SB, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, S0, SB, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, S2, S2, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, S2, S2, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, S2, S1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, S2, S1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, S3, SB, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, S2, S1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, S2, S1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, S3, SB, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, SB, SB, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, S0, SB, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, S0, SB, 1'b0, 1'b0, 1'b0};

    reset = 1'b0; prendido = 1'b1; color = 1'b0; escanear = 1'b0; imprimir = 1'b0;
    ajustes = 2'd0; paginas = 2'd0; rellenar_color = 1'b0; rellenar_negro = 1'b0;

    // Reset with refill, a 2-page colour print, imprimir priority, power cycle.
    for (int i = 0; i < 13; i++) begin
      reset = tbl[i].rst; prendido = tbl[i].on; color = tbl[i].col;
      escanear = tbl[i].esc; imprimir = tbl[i].imp; ajustes = tbl[i].aj;
      paginas = tbl[i].pag; rellenar_color = tbl[i].rc; rellenar_negro = tbl[i].rn;
      tick();
      chk($sformatf("vec%0d_d1", i), display1, tbl[i].d1);
      chk($sformatf("vec%0d_d2", i), display2, tbl[i].d2);
      chk($sformatf("vec%0d_esc", i), esc_escaner, tbl[i].e);
      chk($sformatf("vec%0d_fc", i), fin_color, tbl[i].fc);
      chk($sformatf("vec%0d_fn", i), fin_negro, tbl[i].fn);
    end
    imprimir = 1'b0; rellenar_negro = 1'b0;

    // Copy: 8 scan cycles, 4 pages x 2 cycles, black 7 -> 3.
    copy_job(S3, 8, "copyA");
    chk("copyA_d2", display2, SB);
    chk("copyA_fn", fin_negro, 0);

    // Same copy again: page 4 finds black empty.
    copy_job(S4, 7, "copyB");
    chk("noink_d2", display2, S1);
    chk("noink_fn", fin_negro, 1);
    chk("noink_fc", fin_color, 0);
    imprimir = 1'b1;
    tick();
    imprimir = 1'b0;
    chk("noink_ignore_cmd", display1, S4);
    rellenar_negro = 1'b1;
    tick();
    rellenar_negro = 1'b0;
    chk("resume_d1", display1, S2);
    chk("resume_d2", display2, S1);
    chk("resume_fn", fin_negro, 0);
    wait_end(10);
    chk("resume_done", display1, S3);

    // Black should now be 6: drain it in 4 + 1 pages, leaving 1.
    do_print(1'b0, 2'd3, 1'b0, 1'b0, "blk4");
    do_print(1'b0, 2'd0, 1'b0, 1'b0, "blk1");

    // Reset on the page-end edge must not charge ink.
    color = 1'b0; paginas = 2'd0; imprimir = 1'b1;
    tick();
    imprimir = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_page_d1", display1, S0);
    chk("rst_page_fn", fin_negro, 0);
    do_print(1'b0, 2'd0, 1'b0, 1'b1, "blk_last");

    // Reset in the middle of a scan.
    ajustes = 2'd1; escanear = 1'b1;
    tick();
    escanear = 1'b0;
    chk("scan1_esc", esc_escaner, 1);
    chk("scan1_d2", display2, S1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_scan_esc", esc_escaner, 0);
    chk("rst_scan_d1", display1, S0);
    chk("rst_scan_d2", display2, SB);
    chk("rst_scan_fn", fin_negro, 1);
    chk("rst_scan_fc", fin_color, 0);

    // Colour ink was 7 -> 5 from the first print: 4 pages leave 1, one more empties it.
    do_print(1'b1, 2'd3, 1'b0, 1'b1, "col4");
    do_print(1'b1, 2'd0, 1'b1, 1'b1, "col1");

    // Power off during print.
    rellenar_color = 1'b1; rellenar_negro = 1'b1;
    tick();
    rellenar_color = 1'b0; rellenar_negro = 1'b0;
    chk("refill_fc", fin_color, 0);
    chk("refill_fn", fin_negro, 0);
    color = 1'b0; paginas = 2'd3; imprimir = 1'b1;
    tick();
    imprimir = 1'b0;
    chk("off_pre_d1", display1, S2);
    prendido = 1'b0;
    tick();
    chk("off_d1", display1, SB);
    chk("off_d2", display2, SB);
    chk("off_esc", esc_escaner, 0);
    imprimir = 1'b1;
    tick();
    chk("off_ignore_d1", display1, SB);
    imprimir = 1'b0; prendido = 1'b1;
    tick();
    chk("on_d1", display1, S0);
    chk("on_d2", display2, SB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
